apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master_if.sv | 32 +++
 rtl/apb_cmd_master.sv | 156 +++++++++++++++
 tb/tb_apb_cmd_master.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - command/response and APB signal bundle for apb_cmd_master
interface apb_cmd_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;

    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - buffered command queue driving an APB master (optional APB_PREADY_EN wait states/timeout)
module apb_cmd_master #(
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic PCLK,
    input  logic PRESET,
    apb_cmd_master_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state;
    state_t        state_next;

    logic [12:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [12:0]   head;

    logic          push;
    logic          pop;
    logic          done;
    logic          timed_out;
    logic          psel;
    logic          penable;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Readiness comes only from the registered count, so a same-cycle pop never frees a slot early.
    assign bus.cmd_ready = (count != FULL_CNT);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign head          = fifo_mem[rd_ptr];

`ifdef APB_PREADY_EN
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [WW-1:0] wait_cnt;

    assign timed_out = (state == ACCESS) && !bus.PREADY && (wait_cnt == WW'(TIMEOUT - 1));
    assign done      = (state == ACCESS) && (bus.PREADY || timed_out);

    always_ff @(posedge PCLK) begin
        if (PRESET || state != ACCESS || done) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic unused_pready;
    assign unused_pready = bus.PREADY;
    assign timed_out     = 1'b0;
    assign done          = (state == ACCESS);
`endif

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = SETUP;
                    pop        = 1'b1;
                end
            end
            SETUP: begin
                psel       = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (done) begin
                    if (count != '0) begin
                        state_next = SETUP;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.PSEL    = psel;
    assign bus.PENABLE = penable;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Address, direction and write data are captured on the pop and held through ACCESS.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            bus.PWRITE <= 1'b0;
            bus.PADDR  <= '0;
            bus.PWDATA <= '0;
        end else if (pop) begin
            bus.PWRITE <= head[12];
            bus.PADDR  <= head[11:8];
            bus.PWDATA <= head[7:0];
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= done;
            bus.rsp_err   <= timed_out;
            bus.rsp_rdata <= (done && !bus.PWRITE && !timed_out) ? bus.PRDATA : 8'h00;
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master (vectors, hand sequences, random vs timeline model)
module tb_apb_cmd_master;
    logic PCLK = 1'b0;
    logic PRESET;

    always #5 PCLK = ~PCLK;

    apb_cmd_master_if bus ();

    apb_cmd_master #(.FIFO_DEPTH(2), .TIMEOUT(15)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus.master)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       w;
        logic [3:0] a;
        logic [7:0] wd;
        logic [7:0] prd;
        logic [7:0] exp_rd;
    } vec_t;

    typedef struct {
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
        int         acc;
        int         start;
    } acc_t;

    vec_t       vecs [6];
    acc_t       mq [$];
    logic [7:0] rq [$];
    logic [7:0] prd_h [0:499];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'h0;
        bus.cmd_wdata = 8'h00;
        bus.PRDATA    = 8'h00;
        bus.PREADY    = 1'b1;
    endtask

    task automatic drive_cmd(input logic w, input logic [3:0] a, input logic [7:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        PRESET = 1'b1;
        step();
        step();
        PRESET = 1'b0;
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ps_cnt;
        int bad;
        idle_inputs();
        PRESET = 1'b1;
        step();
        step();
        check("rst_psel", bus.PSEL, 0);
        check("rst_penable", bus.PENABLE, 0);
        check("rst_pwrite", bus.PWRITE, 0);
        check("rst_paddr", bus.PADDR, 0);
        check("rst_pwdata", bus.PWDATA, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        PRESET = 1'b0;
        step();

        // Single transfers from idle: latency and captured values.
        vecs[0] = '{1'b1, 4'h0, 8'h02, 8'h5A, 8'h00};
        vecs[1] = '{1'b0, 4'h1, 8'h00, 8'hA5, 8'hA5};
        vecs[2] = '{1'b1, 4'hF, 8'hFF, 8'h00, 8'h00};
        vecs[3] = '{1'b0, 4'h7, 8'h11, 8'h00, 8'h00};
        vecs[4] = '{1'b0, 4'hA, 8'h33, 8'h3C, 8'h3C};
        vecs[5] = '{1'b1, 4'h5, 8'hC3, 8'hFF, 8'h00};
        for (int i = 0; i < 6; i++) begin
            drive_cmd(vecs[i].w, vecs[i].a, vecs[i].wd);
            check("vec_cmd_ready", bus.cmd_ready, 1);
            step();
            bus.cmd_valid = 1'b0;
            check("vec_idle_psel", bus.PSEL, 0);
            step();
            check("vec_setup_psel", bus.PSEL, 1);
            check("vec_setup_penable", bus.PENABLE, 0);
            check("vec_setup_pwrite", bus.PWRITE, vecs[i].w);
            check("vec_setup_paddr", bus.PADDR, vecs[i].a);
            check("vec_setup_pwdata", bus.PWDATA, vecs[i].wd);
            step();
            bus.PRDATA = vecs[i].prd;
            check("vec_access_psel", bus.PSEL, 1);
            check("vec_access_penable", bus.PENABLE, 1);
            check("vec_access_pwrite", bus.PWRITE, vecs[i].w);
            check("vec_access_paddr", bus.PADDR, vecs[i].a);
            check("vec_access_pwdata", bus.PWDATA, vecs[i].wd);
            check("vec_access_rsp_valid", bus.rsp_valid, 0);
            step();
            bus.PRDATA = ~vecs[i].prd;
            check("vec_rsp_valid", bus.rsp_valid, 1);
            check("vec_rsp_rdata", bus.rsp_rdata, vecs[i].exp_rd);
            check("vec_rsp_err", bus.rsp_err, 0);
            check("vec_rsp_psel", bus.PSEL, 0);
            step();
            check("vec_rsp_pulse_end", bus.rsp_valid, 0);
        end

        // Three back-to-back commands into a depth-2 buffer.
        do_reset();
        drive_cmd(1'b1, 4'h2, 8'h81);
        step();
        ps_cnt = 0;
        rq.delete();
        for (int j = 0; j < 12; j++) begin
            bus.PRDATA = 8'h40 + 8'(j);
            if (j == 0) begin
                check("b2b_ready_b", bus.cmd_ready, 1);
                drive_cmd(1'b0, 4'h3, 8'h00);
            end else if (j == 1) begin
                check("b2b_ready_c", bus.cmd_ready, 1);
                drive_cmd(1'b0, 4'h4, 8'h00);
            end else begin
                bus.cmd_valid = 1'b0;
                if (j == 2) check("b2b_ready_full", bus.cmd_ready, 0);
                if (j == 4) check("b2b_ready_free", bus.cmd_ready, 1);
            end
            if (bus.PSEL) ps_cnt++;
            if (j >= 1 && j <= 6) check("b2b_psel_cont", bus.PSEL, 1);
            if (bus.rsp_valid) rq.push_back(bus.rsp_rdata);
            step();
        end
        check("b2b_psel_cycles", ps_cnt, 6);
        check("b2b_rsp_count", rq.size(), 3);
        if (rq.size() == 3) begin
            check("b2b_rsp0", rq[0], 8'h00);
            check("b2b_rsp1", rq[1], 8'h44);
            check("b2b_rsp2", rq[2], 8'h46);
        end

        // Reset during ACCESS with a second command queued.
        do_reset();
        drive_cmd(1'b1, 4'h6, 8'h99);
        step();
        drive_cmd(1'b0, 4'h8, 8'h00);
        step();
        bus.cmd_valid = 1'b0;
        step();
        check("abort_in_access", bus.PENABLE, 1);
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        check("abort_psel", bus.PSEL, 0);
        check("abort_penable", bus.PENABLE, 0);
        check("abort_cmd_ready", bus.cmd_ready, 1);
        bad = 0;
        for (int j = 0; j < 8; j++) begin
            if (bus.rsp_valid || bus.PSEL) bad++;
            step();
        end
        check("abort_no_activity", bad, 0);

`ifdef APB_PREADY_EN
        begin
            int acc;
            logic got;
            logic [7:0] rd;
            logic er;
            do_reset();
            drive_cmd(1'b0, 4'h9, 8'h00);
            step();
            bus.cmd_valid = 1'b0;
            acc = 0;
            got = 1'b0;
            rd = 8'h00;
            er = 1'b0;
            for (int j = 0; j < 40 && !got; j++) begin
                if (bus.rsp_valid) begin
                    got = 1'b1;
                    rd = bus.rsp_rdata;
                    er = bus.rsp_err;
                end else if (bus.PENABLE) begin
                    acc++;
                end
                bus.PREADY = (acc >= 4);
                bus.PRDATA = 8'h77;
                step();
            end
            check("wait_rsp_seen", got, 1);
            check("wait_access_cycles", acc, 4);
            check("wait_rdata", rd, 8'h77);
            check("wait_err", er, 0);

            bus.PREADY = 1'b0;
            drive_cmd(1'b0, 4'hB, 8'h00);
            step();
            bus.cmd_valid = 1'b0;
            acc = 0;
            got = 1'b0;
            for (int j = 0; j < 60 && !got; j++) begin
                if (bus.rsp_valid) begin
                    got = 1'b1;
                    rd = bus.rsp_rdata;
                    er = bus.rsp_err;
                end else if (bus.PENABLE) begin
                    acc++;
                end
                step();
            end
            check("tmo_rsp_seen", got, 1);
            check("tmo_access_cycles", acc, 15);
            check("tmo_rdata", rd, 8'h00);
            check("tmo_err", er, 1);
            bus.PREADY = 1'b1;
        end
`endif

        // Random traffic against a timeline model: each command's SETUP edge follows from its
        // acceptance edge and the previous command's completion edge.
        do_reset();
        begin
            int prev_start;
            int nrsp;
            prev_start = -100;
            nrsp = 0;
            mq.delete();
            for (int c = 0; c < 450; c++) begin
                int occ;
                int act;
                int rsp;
                logic exp_ready;
                occ = 0;
                act = -1;
                rsp = -1;
                foreach (mq[k]) begin
                    if (mq[k].acc <= c) occ++;
                    if (mq[k].start <= c) occ--;
                    if (mq[k].start <= c && c <= mq[k].start + 1) act = k;
                    if (mq[k].start + 2 == c) rsp = k;
                end
                exp_ready = (occ < 2);
                check("rnd_cmd_ready", bus.cmd_ready, exp_ready);
                check("rnd_psel", bus.PSEL, act >= 0);
                check("rnd_penable", bus.PENABLE, act >= 0 && c == mq[act].start + 1);
                if (act >= 0) begin
                    check("rnd_pwrite", bus.PWRITE, mq[act].w);
                    check("rnd_paddr", bus.PADDR, mq[act].a);
                    check("rnd_pwdata", bus.PWDATA, mq[act].d);
                end
                check("rnd_rsp_valid", bus.rsp_valid, rsp >= 0);
                if (rsp >= 0) begin
                    nrsp++;
                    check("rnd_rsp_rdata", bus.rsp_rdata, mq[rsp].w ? 8'h00 : prd_h[c-1]);
                    check("rnd_rsp_err", bus.rsp_err, 0);
                end
                bus.PRDATA = 8'($urandom);
                prd_h[c] = bus.PRDATA;
                bus.cmd_valid = (c < 430) && ($urandom_range(0, 99) < (c / 100 + 1) * 20);
                bus.cmd_write = 1'($urandom);
                bus.cmd_addr  = 4'($urandom);
                bus.cmd_wdata = 8'($urandom);
                if (bus.cmd_valid && exp_ready) begin
                    acc_t e;
                    e.w = bus.cmd_write;
                    e.a = bus.cmd_addr;
                    e.d = bus.cmd_wdata;
                    e.acc = c + 1;
                    e.start = (c + 1 < prev_start + 2) ? prev_start + 2 : c + 2;
                    prev_start = e.start;
                    mq.push_back(e);
                end
                step();
            end
            check("rnd_all_responses", nrsp, mq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
